v74x148_seq: RTL and testbench

V74X148_SEQ -- requirements
Module: v74x148_seq

---
 rtl/v74x148_seq.sv | 113 +++++++++++
 tb/tb_v74x148_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/v74x148_seq.sv
// Sequential 8-line priority encoder with edge-captured pending requests,
// a two-state present/acknowledge handshake and a sticky overrun flag.
module v74x148_seq (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EI_L,
  input  logic [7:0] I_L,
  input  logic       ACK,
  output logic       VALID,
  output logic [2:0] A_L,
  output logic       GS_L,
  output logic       EO_L,
  output logic       OVR
);

  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned CODE_W    = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   prev_q;
  logic [NUM_LINES-1:0]   pend_q, pend_d;
  logic [NUM_LINES-1:0]   fall, new_req, clr;
  logic [CODE_W-1:0]      code_q, code_d;
  logic [CODE_W-1:0]      top_idx;
  logic                   valid_d;
  logic [CODE_W-1:0]      a_l_d;
  logic                   ovr_d;

  // Index of the highest-priority pending request (bit 7 wins).
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (pend_q[i]) top_idx = CODE_W'(i);
    end
  end

  // Falling-edge capture, acknowledge clear and overrun detection.
  always_comb begin
    fall    = prev_q & ~I_L;
    new_req = fall & {NUM_LINES{~EI_L}};
    clr     = '0;
    if (state_q == PRESENT && ACK) clr[code_q] = 1'b1;
    // A fresh capture on the bit being acknowledged survives the clear.
    pend_d  = (pend_q & ~clr) | new_req;
    ovr_d   = OVR | (|(new_req & pend_q & ~clr));
  end

  // Next-state and registered-output decode for the presentation FSM.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = VALID;
    a_l_d   = A_L;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d = PRESENT;
          code_d  = top_idx;
          valid_d = 1'b1;
          a_l_d   = ~top_idx;
        end else begin
          valid_d = 1'b0;
          a_l_d   = '1;
        end
      end
      PRESENT: begin
        // Code stays frozen until the consumer acknowledges it.
        if (ACK) begin
          state_d = IDLE;
          valid_d = 1'b0;
          a_l_d   = '1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        a_l_d   = '1;
      end
    endcase
  end

  // State, pending set and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      prev_q  <= '1;
      pend_q  <= '0;
      code_q  <= '0;
      VALID   <= 1'b0;
      A_L     <= '1;
      GS_L    <= 1'b1;
      OVR     <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= I_L;
      pend_q  <= pend_d;
      code_q  <= code_d;
      VALID   <= valid_d;
      A_L     <= a_l_d;
      GS_L    <= ~valid_d;
      OVR     <= ovr_d;
    end
  end

  // Enable-out: enabled, nothing pending and nothing being presented.
  assign EO_L = ~(~EI_L && (pend_q == '0) && (state_q == IDLE));

endmodule

// File: tb/tb_v74x148_seq.sv
// Bench for v74x148_seq: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_v74x148_seq;

  logic       clk;
  logic       rst_n;
  logic       ei_l;
  logic [7:0] i_l;
  logic       ack;
  logic       valid;
  logic [2:0] a_l;
  logic       gs_l;
  logic       eo_l;
  logic       ovr;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Behavioural model: request lines as a set of pending indices.
  bit       m_prev [8];
  bit       m_pend [8];
  bit       m_busy;
  int       m_code;
  bit       m_ovr;

  v74x148_seq dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .EI_L  (ei_l),
    .I_L   (i_l),
    .ACK   (ack),
    .VALID (valid),
    .A_L   (a_l),
    .GS_L  (gs_l),
    .EO_L  (eo_l),
    .OVR   (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit any_pend();
    for (int i = 0; i < 8; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int highest_pend();
    for (int i = 7; i >= 0; i--) if (m_pend[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] exp_a_l();
    return m_busy ? 3'(7 - m_code) : 3'd7;
  endfunction

  function automatic logic exp_eo_l();
    return !((ei_l == 1'b0) && !any_pend() && !m_busy);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_prev[i] = 1'b1;
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_code = 0;
    m_ovr  = 1'b0;
  endtask

  // One rising edge of the model, using the inputs held across that edge.
  task automatic model_step();
    bit captured [8];
    bit cleared  [8];
    bit was_pend;
    int top;
    for (int i = 0; i < 8; i++) begin
      captured[i] = m_prev[i] && !i_l[i] && !ei_l;
      cleared[i]  = m_busy && ack && (m_code == i);
      if (captured[i] && m_pend[i] && !cleared[i]) m_ovr = 1'b1;
    end
    was_pend = any_pend();
    top      = highest_pend();
    if (!m_busy) begin
      if (was_pend) begin
        m_busy = 1'b1;
        m_code = top;
      end
    end else if (ack) begin
      m_busy = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (cleared[i]) m_pend[i] = 1'b0;
      if (captured[i]) m_pend[i] = 1'b1;
      m_prev[i] = i_l[i];
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic cyc(input logic ei, input logic [7:0] il, input logic a);
    ei_l = ei;
    i_l  = il;
    ack  = a;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 8'(valid), 8'h0);
    check("rst_a_l",   8'(a_l),   8'h7);
    check("rst_gs_l",  8'(gs_l),  8'h1);
    check("rst_ovr",   8'(ovr),   8'h0);
    ei_l = 1'b0;
    i_l  = 8'hFF;
    ack  = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", 8'(valid), 8'(m_busy));
      check("m_a_l",   8'(a_l),   8'(exp_a_l()));
      check("m_gs_l",  8'(gs_l),  8'(!m_busy));
      check("m_eo_l",  8'(eo_l),  8'(exp_eo_l()));
      check("m_ovr",   8'(ovr),   8'(m_ovr));
    end
  end

  initial begin
    rst_n = 1'b1;
    ei_l  = 1'b0;
    i_l   = 8'hFF;
    ack   = 1'b0;
    model_reset();
    #2;
    do_reset();
    chk_en = 1'b1;

    // Idle with no requests.
    repeat (5) cyc(1'b0, 8'hFF, 1'b0);
    check("idle_valid", 8'(valid), 8'h0);
    check("idle_a_l",   8'(a_l),   8'h7);
    check("idle_gs_l",  8'(gs_l),  8'h1);
    check("idle_eo_l",  8'(eo_l),  8'h0);
    check("idle_ovr",   8'(ovr),   8'h0);

    // Two simultaneous requests served in priority order with a bubble.
    cyc(1'b0, 8'hDB, 1'b0);
    check("db_eo_busy", 8'(eo_l), 8'h1);
    cyc(1'b0, 8'hDB, 1'b0);
    check("db_code5", 8'(a_l), 8'h2);
    check("db_v5",    8'(valid), 8'h1);
    cyc(1'b0, 8'hDB, 1'b1);
    check("db_bubble", 8'(valid), 8'h0);
    cyc(1'b0, 8'hDB, 1'b0);
    check("db_code2", 8'(a_l), 8'h5);
    cyc(1'b0, 8'hDB, 1'b1);
    check("db_done_v",  8'(valid), 8'h0);
    check("db_done_eo", 8'(eo_l),  8'h0);
    cyc(1'b0, 8'hFF, 1'b0);

    // Higher priority arrival does not preempt the presented code.
    cyc(1'b0, 8'hFB, 1'b0);
    cyc(1'b0, 8'hFB, 1'b0);
    check("pre_code2", 8'(a_l), 8'h5);
    cyc(1'b0, 8'h7B, 1'b0);
    check("pre_hold1", 8'(a_l), 8'h5);
    cyc(1'b0, 8'hFB, 1'b0);
    check("pre_hold2", 8'(a_l), 8'h5);
    cyc(1'b0, 8'hFB, 1'b1);
    cyc(1'b0, 8'hFF, 1'b0);
    check("pre_code7", 8'(a_l), 8'h0);
    cyc(1'b0, 8'hFF, 1'b1);

    // Enable high blocks capture; enable low captures the same pulse.
    cyc(1'b1, 8'hF7, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0);
    check("ei_blocked", 8'(valid), 8'h0);
    check("ei_eo_hi",   8'(eo_l),  8'h1);
    cyc(1'b0, 8'hF7, 1'b0);
    cyc(1'b0, 8'hFF, 1'b0);
    check("ei_code3", 8'(a_l), 8'h4);
    cyc(1'b0, 8'hFF, 1'b1);

    // Double capture on a still-pending line sets the sticky overrun.
    cyc(1'b0, 8'hBF, 1'b0);
    cyc(1'b0, 8'hFF, 1'b0);
    check("ovr_code6", 8'(a_l), 8'h1);
    cyc(1'b0, 8'hEF, 1'b0);
    check("ovr_once", 8'(ovr), 8'h0);
    cyc(1'b0, 8'hFF, 1'b0);
    cyc(1'b0, 8'hEF, 1'b0);
    check("ovr_set", 8'(ovr), 8'h1);
    cyc(1'b0, 8'hFF, 1'b1);
    cyc(1'b0, 8'hFF, 1'b0);
    check("ovr_code4", 8'(a_l), 8'h3);
    cyc(1'b0, 8'hFF, 1'b1);
    repeat (3) cyc(1'b0, 8'hFF, 1'b0);
    check("ovr_sticky", 8'(ovr), 8'h1);

    // Reset while presenting with more requests pending.
    cyc(1'b0, 8'hEE, 1'b0);
    cyc(1'b0, 8'hFF, 1'b0);
    check("rp_valid", 8'(valid), 8'h1);
    check("rp_code4", 8'(a_l),   8'h3);
    do_reset();
    repeat (3) cyc(1'b0, 8'hFF, 1'b0);
    check("rp_after", 8'(valid), 8'h0);

    // Held-low lines at reset release count as falls.
    rst_n = 1'b0;
    #1;
    model_reset();
    i_l = 8'hFD;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 8'hFD, 1'b0);
    cyc(1'b0, 8'hFD, 1'b0);
    check("rel_code1", 8'(a_l), 8'h6);
    cyc(1'b0, 8'hFD, 1'b1);
    repeat (3) cyc(1'b0, 8'hFD, 1'b0);
    check("rel_once", 8'(valid), 8'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic       r_ei;
      logic [7:0] r_il;
      logic       r_ack;
      r_ei = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < 8; b++) r_il[b] = ($urandom_range(0, 3) != 0);
      r_ack = $urandom_range(0, 1);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(r_ei, r_il, r_ack);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
